// File: rtl/instruction_ram_loader_pkg.sv
// Shared definitions for the instruction RAM loader: word geometry, default
// RAM geometry and the loader FSM state encoding.
package instruction_ram_loader_pkg;

    localparam int BYTES_PER_WORD     = 4;
    localparam int INSTR_WIDTH        = 32;
    localparam int RAM_DEPTH_DEFAULT  = 98;
    localparam int ADDR_WIDTH_DEFAULT = 10;
    localparam int BYTE_INDEX_WIDTH   = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_ASSEMBLE = 3'd2,
        ST_WRITE    = 3'd3,
        ST_FINISH   = 3'd4
    } loader_state_e;

    // Load window [base, base+count) must lie entirely inside the RAM.
    function automatic logic range_fail(
        input logic [ADDR_WIDTH_DEFAULT:0] base_ext,
        input logic [ADDR_WIDTH_DEFAULT:0] end_ext,
        input logic [ADDR_WIDTH_DEFAULT:0] depth_ext
    );
        return (base_ext >= depth_ext) || (end_ext > depth_ext);
    endfunction

endpackage

// File: rtl/instruction_ram_loader_byte_word_assembler.sv
// Packs accepted stream bytes MSB-first into one instruction word and flags
// the accept that completes the word.
module instruction_ram_loader_byte_word_assembler
    import instruction_ram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = INSTR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_next_o,
    output logic                  word_complete_o
);

    localparam logic [BYTE_INDEX_WIDTH-1:0] LAST_INDEX = BYTE_INDEX_WIDTH'(BYTES_PER_WORD - 1);
    localparam logic [BYTE_INDEX_WIDTH-1:0] INDEX_ONE  = BYTE_INDEX_WIDTH'(1);

    logic [DATA_WIDTH-1:0]       word_q;
    logic [DATA_WIDTH-1:0]       word_d;
    logic [BYTE_INDEX_WIDTH-1:0] index_q;
    logic [BYTE_INDEX_WIDTH-1:0] index_d;

    // Next word/index; the index wraps to zero after the final byte of a word.
    always_comb begin
        word_next_o     = {word_q[DATA_WIDTH-9:0], byte_i};
        word_complete_o = accept_i && (index_q == LAST_INDEX);
        word_d          = word_q;
        index_d         = index_q;
        if (clear_i) begin
            word_d  = {DATA_WIDTH{1'b0}};
            index_d = {BYTE_INDEX_WIDTH{1'b0}};
        end else if (accept_i) begin
            word_d  = word_next_o;
            index_d = index_q + INDEX_ONE;
        end else begin
            word_d  = word_q;
            index_d = index_q;
        end
    end

    // Shift register and byte index state.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_q  <= {DATA_WIDTH{1'b0}};
            index_q <= {BYTE_INDEX_WIDTH{1'b0}};
        end else begin
            word_q  <= word_d;
            index_q <= index_d;
        end
    end

endmodule

// File: rtl/instruction_ram_loader.sv
// Streams bytes into 32-bit instruction words and writes them to the
// instruction RAM at consecutive addresses after a range check.
module instruction_ram_loader
    import instruction_ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int DATA_WIDTH = INSTR_WIDTH,
    parameter int RAM_DEPTH  = RAM_DEPTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    loader_state_e         state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] remaining_q;
    logic                  byte_ready_q;
    logic                  write_enable_q;
    logic [ADDR_WIDTH-1:0] write_address_q;
    logic [DATA_WIDTH-1:0] write_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic                  byte_accept_d;
    logic                  clear_d;
    logic                  word_complete_d;
    logic [DATA_WIDTH-1:0] word_next_d;
    logic [ADDR_WIDTH:0]   base_ext_d;
    logic [ADDR_WIDTH:0]   end_ext_d;
    logic                  range_error_d;

    // Handshake qualification and the CHECK-state range evaluation.
    always_comb begin
        byte_accept_d = byte_valid && byte_ready_q && (state_q == ST_ASSEMBLE);
        clear_d       = (state_q == ST_CHECK);
        base_ext_d    = {1'b0, addr_q};
        end_ext_d     = {1'b0, addr_q} + {1'b0, remaining_q};
        range_error_d = (base_ext_d >= DEPTH_EXT) || (end_ext_d > DEPTH_EXT);
    end

    instruction_ram_loader_byte_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_assembler (
        .clock           (clock),
        .reset           (reset),
        .clear_i         (clear_d),
        .accept_i        (byte_accept_d),
        .byte_i          (byte_in),
        .word_next_o     (word_next_d),
        .word_complete_o (word_complete_d)
    );

    // Loader FSM; every output is registered and asserted on entry to its state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= ADDR_ZERO;
            remaining_q     <= ADDR_ZERO;
            byte_ready_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= ADDR_ZERO;
            write_data_q    <= {DATA_WIDTH{1'b0}};
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            write_enable_q <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    byte_ready_q <= 1'b0;
                    if (start) begin
                        addr_q      <= base_address;
                        remaining_q <= word_count;
                        busy_q      <= 1'b1;
                        state_q     <= ST_CHECK;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (remaining_q == ADDR_ZERO) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end else if (range_error_d) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= ST_FINISH;
                    end else begin
                        byte_ready_q <= 1'b1;
                        state_q      <= ST_ASSEMBLE;
                    end
                end
                ST_ASSEMBLE: begin
                    if (word_complete_d) begin
                        byte_ready_q    <= 1'b0;
                        write_enable_q  <= 1'b1;
                        write_address_q <= addr_q;
                        write_data_q    <= word_next_d;
                        state_q         <= ST_WRITE;
                    end else begin
                        byte_ready_q <= 1'b1;
                        state_q      <= ST_ASSEMBLE;
                    end
                end
                ST_WRITE: begin
                    addr_q      <= addr_q + ADDR_ONE;
                    remaining_q <= remaining_q - ADDR_ONE;
                    if (remaining_q == ADDR_ONE) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end else begin
                        byte_ready_q <= 1'b1;
                        state_q      <= ST_ASSEMBLE;
                    end
                end
                ST_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    byte_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready        = byte_ready_q;
    assign ram_write_enable  = write_enable_q;
    assign ram_write_address = write_address_q;
    assign ram_write_data    = write_data_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule
